// File: rtl/uart_loop_checker_pkg.sv
// Shared definitions for the UART loop checker: FSM state encoding, bus-cycle
// phases and the 8-bit Fibonacci LFSR used to generate the test pattern.
package uart_loop_checker_pkg;

    // Top-level run sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG     = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_WR      = 3'd3,
        ST_WAIT_RX = 3'd4,
        ST_RD      = 3'd5,
        ST_CHECK   = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    // Phases of a single CPU-side bus access
    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_SETUP  = 2'd1,
        BUS_STROBE = 2'd2,
        BUS_HOLD   = 2'd3
    } bus_phase_t;

    // Feedback taps q[7], q[5], q[4], q[3]
    localparam logic [7:0] LFSR_TAP_MASK = 8'b1011_1000;

    // Next LFSR value: shift left, feed back the XOR of the tapped bits
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        lfsr_next = {q[6:0], ^(q & LFSR_TAP_MASK)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01
    function automatic logic [7:0] seed_sanitize(input logic [7:0] s);
        if (s == 8'h00) begin
            seed_sanitize = 8'h01;
        end else begin
            seed_sanitize = s;
        end
    endfunction

endpackage

// File: rtl/uart_bus_cycle.sv
// One CPU-side bus access (write or read) towards the UART:
// SETUP (1 cycle) -> STROBE (STROBE_LEN cycles) -> HOLD (1 cycle).
// The requester holds req high; ack is high during HOLD, so the requester
// leaves its state on the same edge that ends the access.
module uart_bus_cycle
    import uart_loop_checker_pkg::*;
#(
    parameter int unsigned STROBE_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       write,
    input  logic       c_nd,
    input  logic [7:0] wdata,
    input  logic [7:0] rdata_in,
    output logic       ack,
    output logic [7:0] rdata,
    output logic       n_cs,
    output logic       n_rd,
    output logic       n_wr,
    output logic       c_nd_q,
    output logic [7:0] wdata_q
);

    localparam logic [15:0] STROBE_LAST = 16'(STROBE_LEN - 1);

    bus_phase_t  phase_r;
    logic [15:0] strobe_cnt_r;
    logic        is_wr_r;
    logic        n_cs_r;
    logic        n_rd_r;
    logic        n_wr_r;
    logic        c_nd_r;
    logic [7:0]  wdata_r;
    logic [7:0]  rdata_r;

    // Phase sequencing, strobe timing, registered bus pins and read capture
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r      <= BUS_IDLE;
            strobe_cnt_r <= 16'd0;
            is_wr_r      <= 1'b0;
            n_cs_r       <= 1'b1;
            n_rd_r       <= 1'b1;
            n_wr_r       <= 1'b1;
            c_nd_r       <= 1'b1;
            wdata_r      <= 8'h00;
            rdata_r      <= 8'h00;
        end else begin
            case (phase_r)
                BUS_IDLE: begin
                    if (req) begin
                        phase_r <= BUS_SETUP;
                        n_cs_r  <= 1'b0;
                        c_nd_r  <= c_nd;
                        wdata_r <= wdata;
                        is_wr_r <= write;
                    end else begin
                        phase_r <= BUS_IDLE;
                    end
                end
                BUS_SETUP: begin
                    phase_r      <= BUS_STROBE;
                    strobe_cnt_r <= 16'd0;
                    if (is_wr_r) begin
                        n_wr_r <= 1'b0;
                    end else begin
                        n_rd_r <= 1'b0;
                    end
                end
                BUS_STROBE: begin
                    if (strobe_cnt_r == STROBE_LAST) begin
                        // Read data is taken on the edge ending the last strobe cycle
                        phase_r <= BUS_HOLD;
                        n_wr_r  <= 1'b1;
                        n_rd_r  <= 1'b1;
                        if (!is_wr_r) begin
                            rdata_r <= rdata_in;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                    end else begin
                        strobe_cnt_r <= strobe_cnt_r + 16'd1;
                    end
                end
                BUS_HOLD: begin
                    phase_r <= BUS_IDLE;
                    n_cs_r  <= 1'b1;
                end
                default: begin
                    phase_r <= BUS_IDLE;
                    n_cs_r  <= 1'b1;
                    n_rd_r  <= 1'b1;
                    n_wr_r  <= 1'b1;
                end
            endcase
        end
    end

    assign ack     = (phase_r == BUS_HOLD);
    assign rdata   = rdata_r;
    assign n_cs    = n_cs_r;
    assign n_rd    = n_rd_r;
    assign n_wr    = n_wr_r;
    assign c_nd_q  = c_nd_r;
    assign wdata_q = wdata_r;

endmodule

// File: rtl/uart_loop_checker.sv
// Self-checking CPU-side bus master for the UART loopback wrapper. It writes
// the control word, then sends an LFSR byte sequence one character at a time
// (stop-and-wait), reads each character back and counts mismatches.
module uart_loop_checker
    import uart_loop_checker_pkg::*;
#(
    parameter logic [7:0]  CTRL_WORD   = 8'h4E,
    parameter int unsigned NUM_CHARS   = 16,
    parameter logic [7:0]  SEED        = 8'h01,
    parameter int unsigned STROBE_LEN  = 2,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] DATA_OUT,
    input  logic       Rx_RDY,
    input  logic       Tx_RDY,
    input  logic       n_INT,
    output logic       C_nD,
    output logic       n_RD,
    output logic       n_WR,
    output logic       n_CS,
    output logic [7:0] DATA_IN,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic       timeout,
    output logic       int_seen
);

    localparam logic [7:0]  SEED_EFF  = seed_sanitize(SEED);
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_CHARS - 1);
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYC - 1);

    state_t      state_r;
    logic [7:0]  lfsr_r;
    logic [7:0]  char_idx_r;
    logic [31:0] wait_cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic [7:0]  err_cnt_r;
    logic        timeout_r;
    logic        int_seen_r;

    logic        bus_req_s;
    logic        bus_write_s;
    logic        bus_c_nd_s;
    logic [7:0]  bus_wdata_s;
    logic        bus_ack_s;
    logic [7:0]  bus_rdata_s;

    // Select which bus access the current state asks for
    always_comb begin
        bus_req_s   = 1'b0;
        bus_write_s = 1'b1;
        bus_c_nd_s  = 1'b0;
        bus_wdata_s = lfsr_r;
        case (state_r)
            ST_CFG: begin
                bus_req_s   = 1'b1;
                bus_c_nd_s  = 1'b1;
                bus_wdata_s = CTRL_WORD;
            end
            ST_WR: begin
                bus_req_s   = 1'b1;
            end
            ST_RD: begin
                bus_req_s   = 1'b1;
                bus_write_s = 1'b0;
            end
            default: begin
                bus_req_s   = 1'b0;
            end
        endcase
    end

    uart_bus_cycle #(
        .STROBE_LEN (STROBE_LEN)
    ) u_bus (
        .clk      (clk),
        .rst      (RST),
        .req      (bus_req_s),
        .write    (bus_write_s),
        .c_nd     (bus_c_nd_s),
        .wdata    (bus_wdata_s),
        .rdata_in (DATA_OUT),
        .ack      (bus_ack_s),
        .rdata    (bus_rdata_s),
        .n_cs     (n_CS),
        .n_rd     (n_RD),
        .n_wr     (n_WR),
        .c_nd_q   (C_nD),
        .wdata_q  (DATA_IN)
    );

    // Run sequencer: configuration, stop-and-wait transfer, checking and status
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            lfsr_r     <= SEED_EFF;
            char_idx_r <= 8'd0;
            wait_cnt_r <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_cnt_r  <= 8'd0;
            timeout_r  <= 1'b0;
            int_seen_r <= 1'b0;
        end else begin
            // Error interrupt is only recorded; the run carries on
            if (busy_r && !n_INT) begin
                int_seen_r <= 1'b1;
            end else begin
                int_seen_r <= int_seen_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_CFG;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        pass_r     <= 1'b0;
                        err_cnt_r  <= 8'd0;
                        timeout_r  <= 1'b0;
                        int_seen_r <= 1'b0;
                        lfsr_r     <= SEED_EFF;
                        char_idx_r <= 8'd0;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_CFG: begin
                    if (bus_ack_s) begin
                        state_r    <= ST_WAIT_TX;
                        wait_cnt_r <= 32'd0;
                    end else begin
                        state_r    <= ST_CFG;
                    end
                end
                ST_WAIT_TX: begin
                    if (Tx_RDY) begin
                        state_r    <= ST_WR;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        timeout_r  <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ST_WR: begin
                    if (bus_ack_s) begin
                        state_r    <= ST_WAIT_RX;
                        wait_cnt_r <= 32'd0;
                    end else begin
                        state_r    <= ST_WR;
                    end
                end
                ST_WAIT_RX: begin
                    if (Rx_RDY) begin
                        state_r    <= ST_RD;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        timeout_r  <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ST_RD: begin
                    if (bus_ack_s) begin
                        state_r    <= ST_CHECK;
                    end else begin
                        state_r    <= ST_RD;
                    end
                end
                ST_CHECK: begin
                    if ((bus_rdata_s != lfsr_r) && (err_cnt_r != 8'hFF)) begin
                        err_cnt_r <= err_cnt_r + 8'd1;
                    end else begin
                        err_cnt_r <= err_cnt_r;
                    end
                    lfsr_r     <= lfsr_next(lfsr_r);
                    char_idx_r <= char_idx_r + 8'd1;
                    wait_cnt_r <= 32'd0;
                    if (char_idx_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT_TX;
                    end
                end
                ST_DONE: begin
                    // Include this cycle's interrupt sample in the verdict
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    pass_r  <= (err_cnt_r == 8'd0) && !timeout_r && !int_seen_r && n_INT;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_cnt  = err_cnt_r;
    assign timeout  = timeout_r;
    assign int_seen = int_seen_r;

endmodule

// File: tb/tb_uart_loop_checker.sv
// Bench for uart_loop_checker: a behavioural UART loop model answers the bus,
// a scoreboard queue holds the expected bus writes, and final status is
// compared against values derived from a reference LFSR model.
module tb_uart_loop_checker;

    localparam logic [7:0] CTRL = 8'h4E;
    localparam logic [7:0] SEED = 8'h01;
    localparam int         NCH  = 16;
    localparam int         SLEN = 2;
    localparam int         TCYC = 500;

    logic       clk = 1'b0;
    logic       RST;
    logic       start;
    logic [7:0] DATA_OUT;
    logic       Rx_RDY;
    logic       Tx_RDY;
    logic       n_INT;
    logic       C_nD;
    logic       n_RD;
    logic       n_WR;
    logic       n_CS;
    logic [7:0] DATA_IN;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic       timeout;
    logic       int_seen;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected bus writes: {C_nD, DATA_IN}
    logic [8:0] exp_q[$];
    int         wr_cnt = 0;

    // Loop model controls and state
    int         m_idx       = 0;
    int         corrupt_idx = -1;
    bit         rx_block    = 1'b0;

    uart_loop_checker #(
        .CTRL_WORD   (CTRL),
        .NUM_CHARS   (NCH),
        .SEED        (SEED),
        .STROBE_LEN  (SLEN),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .start    (start),
        .DATA_OUT (DATA_OUT),
        .Rx_RDY   (Rx_RDY),
        .Tx_RDY   (Tx_RDY),
        .n_INT    (n_INT),
        .C_nD     (C_nD),
        .n_RD     (n_RD),
        .n_WR     (n_WR),
        .n_CS     (n_CS),
        .DATA_IN  (DATA_IN),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .timeout  (timeout),
        .int_seen (int_seen)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_lfsr(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // Bus monitor: pops the scoreboard on every write strobe, checks strobe width
    initial begin
        logic       prev_n_wr;
        int         low_len;
        logic [8:0] e;
        prev_n_wr = 1'b1;
        low_len   = 0;
        forever begin
            @(negedge clk);
            if (prev_n_wr && !n_WR) begin
                wr_cnt++;
                low_len = 1;
                check_eq("wr_n_cs", n_CS, 1'b0);
                check_eq("wr_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("wr_c_nd", C_nD, e[8]);
                    check_eq("wr_data", DATA_IN, e[7:0]);
                end
            end else if (!n_WR) begin
                low_len++;
            end else if (!prev_n_wr && !n_CS) begin
                check_eq("wr_strobe_len", low_len, SLEN);
            end
            prev_n_wr = n_WR;
        end
    end

    // Behavioural UART loop: one character in flight, optional corruption/blocking
    initial begin
        logic       prev_wr;
        logic       prev_rd;
        logic [7:0] pend;
        bit         pend_v;
        int         rx_dly;
        int         tx_hold;
        prev_wr = 1'b1; prev_rd = 1'b1; pend = 8'h00; pend_v = 1'b0;
        rx_dly = 0; tx_hold = 0;
        Rx_RDY = 1'b0; Tx_RDY = 1'b1; DATA_OUT = 8'h00;
        forever begin
            @(negedge clk);
            if (RST) begin
                pend_v = 1'b0; rx_dly = 0; tx_hold = 0;
                Rx_RDY = 1'b0; Tx_RDY = 1'b1;
                prev_wr = 1'b1; prev_rd = 1'b1;
            end else begin
                if (prev_wr && !n_WR && !n_CS && !C_nD) begin
                    pend = DATA_IN;
                    if (m_idx == corrupt_idx) pend = pend ^ 8'h01;
                    m_idx++;
                    pend_v  = 1'b1;
                    rx_dly  = 2 + (m_idx % 5);
                    tx_hold = 14;
                end
                if (prev_rd && !n_RD && !n_CS) begin
                    Rx_RDY = 1'b0;
                    pend_v = 1'b0;
                end
                if (pend_v && rx_dly > 0) begin
                    rx_dly--;
                end else if (pend_v && !rx_block) begin
                    Rx_RDY   = 1'b1;
                    DATA_OUT = pend;
                end
                if (tx_hold > 0) tx_hold--;
                Tx_RDY  = (tx_hold == 0);
                prev_wr = n_WR;
                prev_rd = n_RD;
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic prepare_run(input int corrupt, input bit block, input int n_data);
        logic [7:0] q;
        exp_q.delete();
        exp_q.push_back({1'b1, CTRL});
        q = SEED;
        for (int i = 0; i < n_data; i++) begin
            exp_q.push_back({1'b0, q});
            q = ref_lfsr(q);
        end
        wr_cnt      = 0;
        m_idx       = 0;
        corrupt_idx = corrupt;
        rx_block    = block;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1'b1);
        check_eq("done_cleared", done, 1'b0);
    endtask

    task automatic wait_wr(input int target, input int bound);
        int n = 0;
        while (wr_cnt < target && n < bound) begin
            cyc(1);
            n++;
        end
        check_eq("wr_reached", wr_cnt >= target, 1'b1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            cyc(1);
            n++;
        end
        check_eq("done_within_bound", done, 1'b1);
    endtask

    task automatic check_final(input logic exp_pass, input logic [7:0] exp_err,
                               input logic exp_to, input logic exp_int, input int exp_wr);
        check_eq("done", done, 1'b1);
        check_eq("busy_end", busy, 1'b0);
        check_eq("pass", pass, exp_pass);
        check_eq("err_cnt", err_cnt, exp_err);
        check_eq("timeout", timeout, exp_to);
        check_eq("int_seen", int_seen, exp_int);
        check_eq("wr_count", wr_cnt, exp_wr);
        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("n_cs_idle", n_CS, 1'b1);
    endtask

    initial begin
        int n;
        RST = 1'b1; start = 1'b0; n_INT = 1'b1;

        // Reset: three cycles, start coincident with reset must be ignored
        cyc(2);
        start = 1'b1;
        cyc(1);
        RST = 1'b0; start = 1'b0;
        cyc(1);
        check_eq("rst_n_cs", n_CS, 1'b1);
        check_eq("rst_n_rd", n_RD, 1'b1);
        check_eq("rst_n_wr", n_WR, 1'b1);
        check_eq("rst_c_nd", C_nD, 1'b1);
        check_eq("rst_data_in", DATA_IN, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pass", pass, 1'b0);
        check_eq("rst_err_cnt", err_cnt, 8'h00);
        check_eq("rst_timeout", timeout, 1'b0);
        check_eq("rst_int_seen", int_seen, 1'b0);

        // Ideal loop, with a stray start mid-run that must be ignored
        prepare_run(-1, 1'b0, NCH);
        pulse_start();
        wait_wr(4, 2000);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_done(5000);
        check_final(1'b1, 8'd0, 1'b0, 1'b0, NCH + 1);

        // Third received byte corrupted (04 -> 05)
        prepare_run(2, 1'b0, NCH);
        pulse_start();
        wait_done(5000);
        check_final(1'b0, 8'd1, 1'b0, 1'b0, NCH + 1);

        // Receiver never ready: timeout exactly TCYC cycles after WAIT_RX entry
        prepare_run(-1, 1'b1, 1);
        pulse_start();
        wait_wr(2, 2000);
        n = 0;
        while (!n_CS && n < 20) begin
            cyc(1);
            n++;
        end
        n = 0;
        while (!timeout && n < 2 * TCYC) begin
            cyc(1);
            n++;
        end
        check_eq("timeout_latency", n, TCYC);
        wait_done(20);
        check_final(1'b0, 8'd0, 1'b1, 1'b0, 2);
        rx_block = 1'b0;

        // One-cycle interrupt pulse during the fifth character
        prepare_run(-1, 1'b0, NCH);
        pulse_start();
        wait_wr(6, 2000);
        n_INT = 1'b0;
        cyc(1);
        n_INT = 1'b1;
        check_eq("int_seen_early", int_seen, 1'b1);
        check_eq("busy_during_int", busy, 1'b1);
        wait_done(5000);
        check_final(1'b0, 8'd0, 1'b0, 1'b1, NCH + 1);

        // Reset during a data write strobe, then a clean rerun from the seed
        prepare_run(-1, 1'b0, NCH);
        pulse_start();
        wait_wr(2, 2000);
        check_eq("abort_in_strobe", n_WR, 1'b0);
        RST = 1'b1;
        cyc(1);
        check_eq("abort_n_wr", n_WR, 1'b1);
        check_eq("abort_n_cs", n_CS, 1'b1);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_int_seen", int_seen, 1'b0);
        check_eq("abort_c_nd", C_nD, 1'b1);
        check_eq("abort_data_in", DATA_IN, 8'h00);
        RST = 1'b0;
        cyc(2);
        prepare_run(-1, 1'b0, NCH);
        pulse_start();
        wait_done(5000);
        check_final(1'b1, 8'd0, 1'b0, 1'b0, NCH + 1);

        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
